execute_stage: RTL
==================

Name: execute_stage

Overview:
- EX stage of the 5-stage MIPS pipeline; sits between the ID/EX register and the memory-access stage.
- Selects forwarded operands, computes the ALU result, zero flag and destination register, and registers them into the EX/MEM pipeline register consumed by the memory-access stage.
- Contains an iterative multiply/divide unit with HI/LO registers; it stalls the front of the pipeline while an operation runs.

Parameters:
- DATA_W, 32, datapath width (only 32 is supported).
- MD_ITER, 32, number of iteration cycles of the multiply/divide unit.

Ports:
- clk  input  1  clock; pipeline registers update on the negative edge.
- rst  input  1  reset.
- stop_debug  input  1  debug freeze; when high, all state holds.
- inWB  input  5  write-back control, passed through.
- inMEM  input  3  memory control, passed through ([1:0] read/write, [2] branch).
- inALUOp  input  5  operation code (package enum).
- inALUSrc  input  1  1 selects inImm as operand B.
- inRegDst  input  1  1 selects inRd as destination, 0 selects inRt.
- inRegA, inRegB  input  32  register-file operands.
- inImm  input  32  sign/zero-extended immediate.
- inRt, inRd, inShamt  input  5  instruction fields.
- fwdA_sel, fwdB_sel  input  2  forwarding select: 00 reg, 01 fwd_mem, 10 fwd_wb, 11 reg.
- fwd_mem, fwd_wb  input  32  forwarded values from EX/MEM and MEM/WB.
- outWB  output  5  registered.
- outMEM  output  3  registered.
- outALUResult  output  32  registered.
- outALUZero  output  1  registered; 1 when the result equals 0.
- outRegB  output  32  registered; forwarded operand B before the ALUSrc mux (store data).
- outRegF_wreg  output  5  registered destination register.
- outStall  output  1  combinational; holds PC, IF/ID and ID/EX.

Behaviour:
- Reset: rst, asynchronous, active-high.
  - All registered outputs, HI and LO clear to 0; the MD FSM goes to IDLE.
  - outStall is 0 during reset.
- Operand selection:
  - opA is inRegA after forwarding.
  - opB_reg is inRegB after forwarding.
  - opB is inImm when inALUSrc=1, otherwise opB_reg.
- Single-cycle ops: ADD, SUB, AND, OR, XOR, NOR, SLT (signed), SLTU, SLL, SRL, SRA, SLLV, SRLV, SRAV, LUI, MFHI, MFLO.
  - Fixed shifts use inShamt; variable shifts use opA[4:0].
  - LUI gives {opB[15:0], 16'h0}.
  - ADD/SUB wrap modulo 2^32; no overflow exception.
- EX/MEM register, on each negedge with stop_debug=0 and outStall=0:
  - Captures inWB, inMEM, the result, zero flag, opB_reg, and wreg = inRegDst ? inRd : inRt.
  - Latency is 1 edge.
- MD unit: MULT, MULTU, DIV, DIVU. FSM states IDLE, BUSY, DONE.
  - IDLE → BUSY when an MD op is present; the counter loads MD_ITER-1 and operands are latched (magnitudes for signed ops).
  - BUSY: one shift-add or shift-subtract step per edge. At count 0 → DONE.
  - DONE: HI/LO are written with the sign-corrected result. The EX/MEM register captures the MD instruction (result field 0). FSM → IDLE.
  - outStall = MD op present AND state != DONE. For MD_ITER=32 the stall lasts 33 cycles.
  - While outStall=1, the EX/MEM register loads a bubble: WB=0, MEM=0, wreg=0, result=0.
- Multiply: MULT gives the signed 64-bit product, MULTU the unsigned product; {HI,LO} = product.
- Divide: LO = quotient, HI = remainder.
  - Signed divide truncates toward zero; the remainder takes the sign of the dividend.
  - Divide by zero: HI = dividend, LO = 32'hFFFFFFFF; still takes full latency.
  - 0x80000000 / -1: LO = 0x80000000, HI = 0.
- MFHI/MFLO immediately after an MD op read the updated HI/LO. Ordering guarantees this, because the MD op leaves EX only in DONE.
- Back-to-back MD ops: the second starts from IDLE on the edge after DONE.
- stop_debug=1 freezes the FSM, counter, HI/LO and EX/MEM register; outStall keeps its value.
- rst mid-operation aborts the op; HI/LO become 0.

Decomposition:
- Package mips_ex_pkg:
  - ALU op enum (5-bit).
  - Forward-select constants.
  - MD FSM state enum.
  - MD_ITER default.
- Sub-module md_unit: iterative mult/div, HI/LO registers, FSM, done flag.

Test Plan:
- ADD opA=7, opB=0xFFFFFFF9 → next negedge outALUResult=0, outALUZero=1; wreg=inRd when RegDst=1.
- Forwarding: fwdA_sel=01, fwd_mem=0x10, inRegA=0x99, SUB with opB=0x10 → result 0, zero=1; fwdB_sel=10 routes fwd_wb to outRegB.
- MULT 0xFFFFFFFE × 3:
  - outStall high exactly 33 cycles; bubbles carry outWB=0.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - Following MFLO outputs 0xFFFFFFFA.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 7 / 0 → LO=0xFFFFFFFF, HI=7.
- stop_debug asserted 5 cycles mid-DIV → stall extends by 5 cycles, same result.
  - rst pulsed mid-MULT → outStall=0, HI=LO=0, all outputs 0.

Source files
------------

// File: rtl/mips_ex_pkg.sv
// Shared types and constants for the MIPS execute stage: ALU operation
// codes, forwarding selects and the multiply/divide sequencer states.
package mips_ex_pkg;

  localparam int MD_ITER_DEF = 32;

  localparam logic [1:0] FWD_REG  = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;
  localparam logic [1:0] FWD_REG2 = 2'b11;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_AND   = 5'd2,
    ALU_OR    = 5'd3,
    ALU_XOR   = 5'd4,
    ALU_NOR   = 5'd5,
    ALU_SLT   = 5'd6,
    ALU_SLTU  = 5'd7,
    ALU_SLL   = 5'd8,
    ALU_SRL   = 5'd9,
    ALU_SRA   = 5'd10,
    ALU_SLLV  = 5'd11,
    ALU_SRLV  = 5'd12,
    ALU_SRAV  = 5'd13,
    ALU_LUI   = 5'd14,
    ALU_MFHI  = 5'd15,
    ALU_MFLO  = 5'd16,
    ALU_MULT  = 5'd17,
    ALU_MULTU = 5'd18,
    ALU_DIV   = 5'd19,
    ALU_DIVU  = 5'd20
  } aluOpT;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } mdStateT;

  // True for the four opcodes handled by the iterative multiply/divide unit.
  function automatic logic isMdOp(input logic [4:0] op);
    return (op == ALU_MULT) || (op == ALU_MULTU) || (op == ALU_DIV) || (op == ALU_DIVU);
  endfunction

endpackage

// File: rtl/execute_stage_md.sv
// Iterative multiply/divide unit with HI/LO. Works on operand magnitudes
// (shift-add multiply, restoring divide) and applies sign correction when
// the result is committed to HI/LO in the DONE state.
module md_unit
  import mips_ex_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MD_ITER = MD_ITER_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stop_debug,
  input  logic              start,
  input  logic [4:0]        op,
  input  logic [DATA_W-1:0] opA,
  input  logic [DATA_W-1:0] opB,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = (MD_ITER > 1) ? $clog2(MD_ITER) : 1;

  mdStateT               state;
  logic [CNT_W-1:0]      cnt;
  logic [2*DATA_W-1:0]   acc, accStep, mulRes;
  logic [DATA_W-1:0]     m, dividend, magA, magB, quoFix, remFix;
  logic [DATA_W:0]       sumMul, remSh, diff;
  logic                  isDiv, negQ, negR, divZero, isSigned, opIsDiv;

  // Operand classification and magnitudes for the op waiting in IDLE.
  always_comb begin
    isSigned = (op == ALU_MULT) || (op == ALU_DIV);
    opIsDiv  = (op == ALU_DIV) || (op == ALU_DIVU);
    magA     = (isSigned && opA[DATA_W-1]) ? -opA : opA;
    magB     = (isSigned && opB[DATA_W-1]) ? -opB : opB;
  end

  // One multiply or divide iteration plus the sign-corrected final results.
  always_comb begin
    sumMul  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, m} : '0);
    remSh   = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    diff    = remSh - {1'b0, m};
    if (isDiv)
      accStep = diff[DATA_W] ? {remSh[DATA_W-1:0], acc[DATA_W-2:0], 1'b0}
                             : {diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
    else
      accStep = {sumMul, acc[DATA_W-1:1]};
    mulRes  = negQ ? -acc : acc;
    quoFix  = negQ ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
    remFix  = negR ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
  end

  assign done = (state == MD_DONE);

  // Sequencer: latch operands, iterate MD_ITER times, commit HI/LO.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state    <= MD_IDLE;
      cnt      <= '0;
      acc      <= '0;
      m        <= '0;
      dividend <= '0;
      isDiv    <= 1'b0;
      negQ     <= 1'b0;
      negR     <= 1'b0;
      divZero  <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else if (!stop_debug) begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            state    <= MD_BUSY;
            cnt      <= CNT_W'(MD_ITER - 1);
            isDiv    <= opIsDiv;
            negQ     <= isSigned && (opA[DATA_W-1] ^ opB[DATA_W-1]);
            negR     <= opIsDiv && isSigned && opA[DATA_W-1];
            divZero  <= opIsDiv && (opB == '0);
            dividend <= opA;
            m        <= opIsDiv ? magB : magA;
            acc      <= {{DATA_W{1'b0}}, (opIsDiv ? magA : magB)};
          end
        end
        MD_BUSY: begin
          acc <= accStep;
          if (cnt == '0) state <= MD_DONE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        MD_DONE: begin
          state <= MD_IDLE;
          if (!isDiv) begin
            hi <= mulRes[2*DATA_W-1:DATA_W];
            lo <= mulRes[DATA_W-1:0];
          end else if (divZero) begin
            hi <= dividend;
            lo <= '1;
          end else begin
            hi <= remFix;
            lo <= quoFix;
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/execute_stage.sv
// MIPS EX stage: operand forwarding, ALU, destination select and the
// EX/MEM pipeline register (negative-edge). Multiply/divide runs in
// md_unit and stalls the front of the pipeline until it reaches DONE.
module execute_stage
  import mips_ex_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MD_ITER = MD_ITER_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stop_debug,
  input  logic [4:0]        inWB,
  input  logic [2:0]        inMEM,
  input  logic [4:0]        inALUOp,
  input  logic              inALUSrc,
  input  logic              inRegDst,
  input  logic [DATA_W-1:0] inRegA,
  input  logic [DATA_W-1:0] inRegB,
  input  logic [DATA_W-1:0] inImm,
  input  logic [4:0]        inRt,
  input  logic [4:0]        inRd,
  input  logic [4:0]        inShamt,
  input  logic [1:0]        fwdA_sel,
  input  logic [1:0]        fwdB_sel,
  input  logic [DATA_W-1:0] fwd_mem,
  input  logic [DATA_W-1:0] fwd_wb,
  output logic [4:0]        outWB,
  output logic [2:0]        outMEM,
  output logic [DATA_W-1:0] outALUResult,
  output logic              outALUZero,
  output logic [DATA_W-1:0] outRegB,
  output logic [4:0]        outRegF_wreg,
  output logic              outStall
);

  logic [DATA_W-1:0] opA, opBReg, opB, aluResult, hi, lo;
  logic              mdOp, mdDone;

  logic [4:0]        exWb_p1;
  logic [2:0]        exMem_p1;
  logic [DATA_W-1:0] exResult_p1, exRegB_p1;
  logic              exZero_p1;
  logic [4:0]        exWreg_p1;

  function automatic logic [DATA_W-1:0] fwdMux(input logic [1:0] sel,
                                               input logic [DATA_W-1:0] regVal,
                                               input logic [DATA_W-1:0] memVal,
                                               input logic [DATA_W-1:0] wbVal);
    case (sel)
      FWD_MEM: return memVal;
      FWD_WB:  return wbVal;
      default: return regVal;
    endcase
  endfunction

  assign opA    = fwdMux(fwdA_sel, inRegA, fwd_mem, fwd_wb);
  assign opBReg = fwdMux(fwdB_sel, inRegB, fwd_mem, fwd_wb);
  assign opB    = inALUSrc ? inImm : opBReg;
  assign mdOp   = isMdOp(inALUOp);
  // Stall holds the front end until the MD op reaches DONE; never during reset.
  assign outStall = !rst && mdOp && !mdDone;

  md_unit #(.DATA_W(DATA_W), .MD_ITER(MD_ITER)) uMd (
    .clk        (clk),
    .rst        (rst),
    .stop_debug (stop_debug),
    .start      (mdOp),
    .op         (inALUOp),
    .opA        (opA),
    .opB        (opB),
    .done       (mdDone),
    .hi         (hi),
    .lo         (lo)
  );

  // Single-cycle ALU; MD ops leave a zero result in the pipeline.
  always_comb begin
    aluResult = '0;
    case (inALUOp)
      ALU_ADD:  aluResult = opA + opB;
      ALU_SUB:  aluResult = opA - opB;
      ALU_AND:  aluResult = opA & opB;
      ALU_OR:   aluResult = opA | opB;
      ALU_XOR:  aluResult = opA ^ opB;
      ALU_NOR:  aluResult = ~(opA | opB);
      ALU_SLT:  aluResult = DATA_W'($signed(opA) < $signed(opB));
      ALU_SLTU: aluResult = DATA_W'(opA < opB);
      ALU_SLL:  aluResult = opB << inShamt;
      ALU_SRL:  aluResult = opB >> inShamt;
      ALU_SRA:  aluResult = $unsigned($signed(opB) >>> inShamt);
      ALU_SLLV: aluResult = opB << opA[4:0];
      ALU_SRLV: aluResult = opB >> opA[4:0];
      ALU_SRAV: aluResult = $unsigned($signed(opB) >>> opA[4:0]);
      ALU_LUI:  aluResult = DATA_W'({opB[15:0], 16'h0000});
      ALU_MFHI: aluResult = hi;
      ALU_MFLO: aluResult = lo;
      default:  aluResult = '0;
    endcase
  end

  // EX -> MEM boundary: capture the instruction, or a bubble while stalled.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      exWb_p1     <= '0;
      exMem_p1    <= '0;
      exResult_p1 <= '0;
      exZero_p1   <= 1'b0;
      exRegB_p1   <= '0;
      exWreg_p1   <= '0;
    end else if (!stop_debug) begin
      if (outStall) begin
        exWb_p1     <= '0;
        exMem_p1    <= '0;
        exResult_p1 <= '0;
        exZero_p1   <= 1'b0;
        exRegB_p1   <= '0;
        exWreg_p1   <= '0;
      end else begin
        exWb_p1     <= inWB;
        exMem_p1    <= inMEM;
        exResult_p1 <= aluResult;
        exZero_p1   <= (aluResult == '0);
        exRegB_p1   <= opBReg;
        exWreg_p1   <= inRegDst ? inRd : inRt;
      end
    end
  end

  assign outWB        = exWb_p1;
  assign outMEM       = exMem_p1;
  assign outALUResult = exResult_p1;
  assign outALUZero   = exZero_p1;
  assign outRegB      = exRegB_p1;
  assign outRegF_wreg = exWreg_p1;

endmodule
